// File: rtl/ram_if_pkg.sv
// Shared definitions for the RAM-side Wishbone initiator.
package ram_if_pkg;

  localparam int unsigned RAM_AW    = 10;
  localparam int unsigned RAM_DW    = 32;
  localparam int unsigned RAM_BYTES = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_ACK,
    S_ERR
  } state_e;

endpackage : ram_if_pkg

// File: rtl/ram_wb_initiator.sv
// Wishbone classic slave bridging a 4 KB address window onto a synchronous
// single-port RAM with byte write enables and one-cycle read latency.
module ram_wb_initiator
  import ram_if_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                 CLK,
  input  logic                 RESETn,
  input  logic                 cyc_i,
  input  logic                 stb_i,
  input  logic                 we_i,
  input  logic [RAM_BYTES-1:0] sel_i,
  input  logic [31:0]          adr_i,
  input  logic [RAM_DW-1:0]    dat_i,
  output logic [RAM_DW-1:0]    dat_o,
  output logic                 ack_o,
  output logic                 err_o,
  output logic                 ram_EN,
  output logic [RAM_BYTES-1:0] ram_WE,
  output logic [RAM_AW-1:0]    ram_A,
  output logic [RAM_DW-1:0]    ram_Di,
  input  logic [RAM_DW-1:0]    ram_Do
);

  state_e state_q, state_d;

  logic                 we_q, we_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic                 en_q, en_d;
  logic [RAM_BYTES-1:0] wen_q, wen_d;
  logic [RAM_AW-1:0]    addr_q, addr_d;
  logic [RAM_DW-1:0]    wdat_q, wdat_d;
  logic [RAM_DW-1:0]    rdat_q, rdat_d;

  logic req;
  logic hit;
  logic issue_start;

  assign req         = cyc_i & stb_i;
  assign hit         = (adr_i[31:12] == BASE_ADDR[31:12]);
  assign issue_start = (state_q == S_IDLE) && (state_d == S_ISSUE);

  // State register, cleared asynchronously
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; dropping cyc_i after issue abandons the handshake
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (req) state_d = hit ? S_ISSUE : S_ERR;
      S_ISSUE:   state_d = !cyc_i ? S_IDLE : (we_q ? S_ACK : S_CAPTURE);
      S_CAPTURE: state_d = !cyc_i ? S_IDLE : S_ACK;
      S_ACK:     state_d = S_IDLE;
      S_ERR:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output next-values are decoded from the next state so every port is a flop
  always_comb begin
    ack_d  = (state_d == S_ACK);
    err_d  = (state_d == S_ERR);
    en_d   = (state_d == S_ISSUE);
    wen_d  = '0;
    addr_d = addr_q;
    wdat_d = wdat_q;
    rdat_d = rdat_q;
    we_d   = we_q;
    if ((state_q == S_IDLE) && req) we_d = we_i;
    if (issue_start) begin
      addr_d = adr_i[RAM_AW+1:2];
      wdat_d = dat_i;
      wen_d  = we_i ? sel_i : '0;
    end
    if (state_q == S_CAPTURE) rdat_d = ram_Do;
  end

  // Output and request-latch registers
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      we_q   <= 1'b0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      en_q   <= 1'b0;
      wen_q  <= '0;
      addr_q <= '0;
      wdat_q <= '0;
      rdat_q <= '0;
    end else begin
      we_q   <= we_d;
      ack_q  <= ack_d;
      err_q  <= err_d;
      en_q   <= en_d;
      wen_q  <= wen_d;
      addr_q <= addr_d;
      wdat_q <= wdat_d;
      rdat_q <= rdat_d;
    end
  end

  assign ack_o  = ack_q;
  assign err_o  = err_q;
  assign ram_EN = en_q;
  assign ram_WE = wen_q;
  assign ram_A  = addr_q;
  assign ram_Di = wdat_q;
  assign dat_o  = rdat_q;

endmodule : ram_wb_initiator

// File: tb/tb_ram_wb_initiator.sv
// Randomised self-checking bench for ram_wb_initiator with a byte-lane RAM model.
module tb_ram_wb_initiator;
  import ram_if_pkg::*;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
  logic [3:0]  sel_i = '0;
  logic [31:0] adr_i = '0, dat_i = '0;
  logic [31:0] dat_o;
  logic        ack_o, err_o, ram_EN;
  logic [3:0]  ram_WE;
  logic [9:0]  ram_A;
  logic [31:0] ram_Di;
  logic [31:0] ram_Do;

  ram_wb_initiator #(.BASE_ADDR(BASE)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i), .sel_i(sel_i),
    .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
    .ack_o(ack_o), .err_o(err_o),
    .ram_EN(ram_EN), .ram_WE(ram_WE), .ram_A(ram_A), .ram_Di(ram_Di),
    .ram_Do(ram_Do)
  );

  always #5 CLK = ~CLK;

  // Synchronous RAM: read-before-write, data valid one clock after enable
  bit [31:0] mem [1024];
  always @(posedge CLK) begin
    if (ram_EN) begin
      for (int b = 0; b < 4; b++)
        if (ram_WE[b]) mem[ram_A][8*b +: 8] <= ram_Di[8*b +: 8];
      ram_Do <= mem[ram_A];
    end
  end

  // Reference memory image maintained purely from the transactions issued
  bit [31:0]   ref_mem [1024];
  logic [31:0] exp_dato = '0;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One Wishbone transaction, checked cycle by cycle for five cycles after sampling
  task automatic run_txn(input logic w, input logic [3:0] s, input logic [31:0] a,
                         input logic [31:0] d, input bit abort);
    bit          hit;
    int          done_at;
    int          ack_at;
    int          err_at;
    int          en_at;
    bit          rd_done;
    logic [31:0] new_dat;
    logic [9:0]  idx;
    hit     = (a[31:12] == BASE[31:12]);
    idx     = a[11:2];
    err_at  = hit ? 0 : 1;
    en_at   = hit ? 1 : 0;
    ack_at  = (!hit || abort) ? 0 : (w ? 2 : 3);
    done_at = (abort || !hit) ? 1 : ack_at;
    rd_done = hit && !w && !abort;
    new_dat = ref_mem[idx];
    @(negedge CLK);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = w; sel_i = s; adr_i = a; dat_i = d;
    @(posedge CLK);
    for (int k = 1; k <= 5; k++) begin
      #1;
      check("ack", {31'b0, ack_o}, {31'b0, k == ack_at});
      check("err", {31'b0, err_o}, {31'b0, k == err_at});
      check("ram_en", {31'b0, ram_EN}, {31'b0, k == en_at});
      if (k == en_at) begin
        check("ram_a", {22'b0, ram_A}, {22'b0, idx});
        check("ram_we", {28'b0, ram_WE}, {28'b0, (w ? s : 4'b0000)});
        check("ram_di", ram_Di, d);
      end else begin
        check("ram_we_idle", {28'b0, ram_WE}, 32'h0);
      end
      check("dat_o", dat_o, (rd_done && k >= 3) ? new_dat : exp_dato);
      @(negedge CLK);
      if (k == done_at) begin
        cyc_i = 1'b0; stb_i = 1'b0;
      end
      @(posedge CLK);
    end
    cyc_i = 1'b0; stb_i = 1'b0;
    if (rd_done) exp_dato = new_dat;
    if (hit && w)
      for (int b = 0; b < 4; b++)
        if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
  endtask

  initial begin
    logic [31:0] a;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_ack", {31'b0, ack_o}, 32'h0);
    check("rst_err", {31'b0, err_o}, 32'h0);
    check("rst_en", {31'b0, ram_EN}, 32'h0);
    check("rst_we", {28'b0, ram_WE}, 32'h0);
    check("rst_a", {22'b0, ram_A}, 32'h0);
    check("rst_di", ram_Di, 32'h0);
    check("rst_dat", dat_o, 32'h0);
    @(negedge CLK);
    RESETn = 1'b1;

    // Directed cases
    run_txn(1'b1, 4'hF, 32'h3000_0010, 32'hDEAD_BEEF, 1'b0);
    run_txn(1'b0, 4'hF, 32'h3000_0010, 32'h0, 1'b0);
    run_txn(1'b1, 4'b0100, 32'h3000_0FFC, 32'h00AB_0000, 1'b0);
    run_txn(1'b0, 4'hF, 32'h3000_0FFC, 32'h0, 1'b0);
    run_txn(1'b0, 4'hF, 32'h3000_1000, 32'h0, 1'b0);
    run_txn(1'b1, 4'hF, 32'h3000_0020, 32'h1234_5678, 1'b1);
    run_txn(1'b0, 4'hF, 32'h3000_0020, 32'h0, 1'b0);
    run_txn(1'b1, 4'h0, 32'h3000_0010, 32'hFFFF_FFFF, 1'b0);
    run_txn(1'b0, 4'hF, 32'h3000_0010, 32'h0, 1'b0);
    run_txn(1'b0, 4'hF, 32'h3000_0020, 32'h0, 1'b1);

    // Randomised traffic concentrated on a few words so reads hit written data
    for (int i = 0; i < 60; i++) begin
      a = BASE | {20'h0, 4'h0, 4'($urandom_range(0, 7)), 4'($urandom)};
      if ($urandom_range(0, 7) == 0) a[31:12] = 20'($urandom);
      if ($urandom_range(0, 15) == 0) a[31:12] = BASE[31:12] + 20'h1;
      run_txn(1'($urandom), 4'($urandom), a, $urandom, $urandom_range(0, 9) == 0);
    end

    // Reset asserted while a read sits in CAPTURE
    @(negedge CLK);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; sel_i = 4'hF; adr_i = 32'h3000_0010;
    @(posedge CLK);
    @(posedge CLK);
    #3;
    RESETn = 1'b0;
    #1;
    check("mid_rst_ack", {31'b0, ack_o}, 32'h0);
    check("mid_rst_err", {31'b0, err_o}, 32'h0);
    check("mid_rst_en", {31'b0, ram_EN}, 32'h0);
    check("mid_rst_we", {28'b0, ram_WE}, 32'h0);
    check("mid_rst_a", {22'b0, ram_A}, 32'h0);
    check("mid_rst_di", ram_Di, 32'h0);
    check("mid_rst_dat", dat_o, 32'h0);
    cyc_i = 1'b0; stb_i = 1'b0;
    exp_dato = '0;
    @(negedge CLK);
    RESETn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK);
      #1;
      check("post_rst_ack", {31'b0, ack_o}, 32'h0);
      check("post_rst_en", {31'b0, ram_EN}, 32'h0);
    end
    run_txn(1'b0, 4'hF, 32'h3000_0FFC, 32'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule : tb_ram_wb_initiator
